// File: rtl/vga_scan_driver.sv
// vga_scan_driver: 640x480@60 raster timing and downscaled x/y source.
// Registers blank-gated colour and active-low syncs one pixel tick late.
module vga_scan_driver #(
  parameter int CLK_DIV     = 2,
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int SCALE_SHIFT = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] color,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic       hsync,
  output logic       vsync,
  output logic [2:0] rgb,
  output logic       video_on,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int HS_LO = H_ACTIVE + H_FP;
  localparam int HS_HI = H_ACTIVE + H_FP + H_SYNC - 1;
  localparam int VS_LO = V_ACTIVE + V_FP;
  localparam int VS_HI = V_ACTIVE + V_FP + V_SYNC - 1;

  logic [DW-1:0] div_q, div_d;
  logic [HW-1:0] hcount_q, hcount_d;
  logic [VW-1:0] vcount_q, vcount_d;
  logic [2:0]    rgb_q, rgb_d;
  logic          video_on_q, video_on_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          tick;
  logic          active;
  logic          h_end;
  logic          v_end;

  assign tick   = (div_q == DW'(CLK_DIV - 1));
  assign h_end  = (hcount_q == HW'(H_TOTAL - 1));
  assign v_end  = (vcount_q == VW'(V_TOTAL - 1));
  assign active = (hcount_q < HW'(H_ACTIVE))
               && (vcount_q < VW'(V_ACTIVE));

  // Pixel divider and raster counters advance on each tick.
  always_comb begin
    div_d    = div_q;
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    if (tick) begin
      div_d = '0;
      if (h_end) begin
        hcount_d = '0;
        vcount_d = v_end ? '0 : vcount_q + 1'b1;
      end else begin
        hcount_d = hcount_q + 1'b1;
      end
    end else begin
      div_d = div_q + 1'b1;
    end
  end

  // Output stage captures the current pixel once per tick.
  always_comb begin
    rgb_d      = rgb_q;
    video_on_d = video_on_q;
    hsync_d    = hsync_q;
    vsync_d    = vsync_q;
    if (tick) begin
      rgb_d      = active ? color : 3'd0;
      video_on_d = active;
      hsync_d    = ~((hcount_q >= HW'(HS_LO))
                  && (hcount_q <= HW'(HS_HI)));
      vsync_d    = ~((vcount_q >= VW'(VS_LO))
                  && (vcount_q <= VW'(VS_HI)));
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q      <= '0;
      hcount_q   <= '0;
      vcount_q   <= '0;
      rgb_q      <= '0;
      video_on_q <= 1'b0;
      hsync_q    <= 1'b1;
      vsync_q    <= 1'b1;
    end else begin
      div_q      <= div_d;
      hcount_q   <= hcount_d;
      vcount_q   <= vcount_d;
      rgb_q      <= rgb_d;
      video_on_q <= video_on_d;
      hsync_q    <= hsync_d;
      vsync_q    <= vsync_d;
    end
  end

  assign x = active ? 8'(hcount_q >> SCALE_SHIFT) : 8'd0;
  assign y = active ? 7'(vcount_q >> SCALE_SHIFT) : 7'd0;

  assign frame_start = tick && !reset
                    && (hcount_q == '0) && (vcount_q == '0);

  assign rgb      = rgb_q;
  assign video_on = video_on_q;
  assign hsync    = hsync_q;
  assign vsync    = vsync_q;

endmodule

// File: tb/tb_vga_scan_driver.sv
// tb_vga_scan_driver: random colour and resets against a tick-index model.
// Small raster so several whole frames fit in a short run.
module tb_vga_scan_driver;

  localparam int CD  = 2;
  localparam int HA  = 40;
  localparam int HFP = 4;
  localparam int HS  = 6;
  localparam int HBP = 6;
  localparam int VA  = 24;
  localparam int VFP = 2;
  localparam int VS  = 2;
  localparam int VBP = 3;
  localparam int SS  = 2;
  localparam int HT  = HA + HFP + HS + HBP;
  localparam int VT  = VA + VFP + VS + VBP;
  localparam int FT  = HT * VT;
  localparam int NCYC = 12000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] color = 3'd0;
  logic [7:0] x;
  logic [6:0] y;
  logic       hsync;
  logic       vsync;
  logic [2:0] rgb;
  logic       video_on;
  logic       frame_start;

  int checks = 0;
  int errors = 0;

  vga_scan_driver #(
    .CLK_DIV(CD), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS),
    .H_BP(HBP), .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS),
    .V_BP(VBP), .SCALE_SHIFT(SS)
  ) dut (
    .clk(clk), .reset(reset), .color(color),
    .x(x), .y(y), .hsync(hsync), .vsync(vsync),
    .rgb(rgb), .video_on(video_on),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d t=%0t",
               tag, got, exp, $time);
    end
  endtask

  initial begin
    int k = 0;
    int cap_valid = 0;
    int cap_n = 0;
    logic [2:0] cap_col = 3'd0;
    int n, h, v, ch, cv;
    bit act, cact, hs_rst_done;
    int fs_obs = 0;
    int fs_exp = 0;
    logic [31:0] ex, ey, ehs, evs, ergb, evon, efs;
    hs_rst_done = 1'b0;

    for (int i = 0; i < NCYC; i++) begin
      @(negedge clk);
      // apply the edge that just happened to the model
      if (reset) begin
        k = 0;
        cap_valid = 0;
      end else begin
        if (k % CD == CD - 1) begin
          cap_valid = 1;
          cap_n = (k / CD) % FT;
          cap_col = color;
        end
        k++;
      end

      n = (k / CD) % FT;
      h = n % HT;
      v = n / HT;
      act = (h < HA) && (v < VA);
      ex = act ? ((h >> SS) & 255) : 0;
      ey = act ? ((v >> SS) & 127) : 0;
      efs = (!reset && (k % CD == CD - 1) && n == 0) ? 1 : 0;

      if (cap_valid != 0) begin
        ch = cap_n % HT;
        cv = cap_n / HT;
        cact = (ch < HA) && (cv < VA);
        ehs = (ch >= HA + HFP && ch < HA + HFP + HS) ? 0 : 1;
        evs = (cv >= VA + VFP && cv < VA + VFP + VS) ? 0 : 1;
        evon = cact ? 1 : 0;
        ergb = cact ? {29'd0, cap_col} : 0;
      end else begin
        ehs = 1;
        evs = 1;
        evon = 0;
        ergb = 0;
      end

      chk("x", {24'd0, x}, ex);
      chk("y", {25'd0, y}, ey);
      chk("hsync", {31'd0, hsync}, ehs);
      chk("vsync", {31'd0, vsync}, evs);
      chk("rgb", {29'd0, rgb}, ergb);
      chk("video_on", {31'd0, video_on}, evon);
      chk("frame_start", {31'd0, frame_start}, efs);
      if (frame_start === 1'b1) fs_obs++;
      if (efs == 1) fs_exp++;

      // next inputs: colour changes every clk, resets are rare
      color = 3'($urandom_range(0, 7));
      if (i < 3) begin
        reset = 1'b1;
      end else if (!hs_rst_done && !reset && i > 4000
                   && h == HA + HFP + 2) begin
        reset = 1'b1;
        hs_rst_done = 1'b1;
      end else if ($urandom_range(0, 3999) == 0) begin
        reset = 1'b1;
      end else begin
        reset = 1'b0;
      end
    end

    chk("hsync_reset_hit", {31'd0, hs_rst_done}, 32'd1);
    chk("frame_count", fs_obs, fs_exp);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
